// File: rtl/sync_down_counter_if.sv
// ----------------------------------------------------------------------------
// Module      : sync_down_counter_if
// Description : Control and status bundle of one sync_down_counter stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface sync_down_counter_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic [WIDTH-1:0] D;
   logic             count_enable;
   logic             reload_mode;
   logic [WIDTH-1:0] Q;
   logic             borrow;
   logic             done;

   // master drives the controls, slave is the counter itself
   modport master (
      output load,
      output D,
      output count_enable,
      output reload_mode,
      input  Q,
      input  borrow,
      input  done
   );

   modport slave (
      input  load,
      input  D,
      input  count_enable,
      input  reload_mode,
      output Q,
      output borrow,
      output done
   );
endinterface

`default_nettype wire

// File: rtl/sync_down_counter.sv
// ----------------------------------------------------------------------------
// Module      : sync_down_counter
// Description : Loadable down counter with one-shot or auto-reload terminal
//               action and a combinational borrow for cascading.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module sync_down_counter #(
   parameter int WIDTH = 4
) (
   input  wire logic           clock,
   input  wire logic           clear,
   sync_down_counter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_terminal;

   // terminal replaces the 0 -> all-ones wrap; load overrides it
   assign w_terminal = (r_state == RUN) && bus.count_enable && (r_q == '0);
   assign bus.borrow = w_terminal && !bus.load;
   assign bus.Q      = r_q;
   assign bus.done   = r_done;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state  <= IDLE;
         r_q      <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_q      <= w_q_nxt;
         r_reload <= w_reload_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_reload_nxt = r_reload;
      w_done_nxt   = r_done;

      if (bus.load) begin
         w_q_nxt      = bus.D;
         w_reload_nxt = bus.D;
         w_state_nxt  = RUN;
         w_done_nxt   = 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (bus.count_enable) begin
                  if (r_q != '0) begin
                     w_q_nxt = r_q - 1'b1;
                  end else if (bus.reload_mode) begin
                     w_q_nxt = r_reload;
                  end else begin
                     w_state_nxt = EXPIRED;
                     w_done_nxt  = 1'b1;
                  end
               end
            end
            EXPIRED: begin
               w_q_nxt    = '0;
               w_done_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
